// File: rtl/key_event_if.sv
// key_event_if
// Groups the key event queue's producer/consumer signals into one bundle.
//   key_pulse  one-cycle key pulses, bit i = key i (producer -> queue)
//   evt_ready  consumer accepts the head event this cycle
//   clr_flags  synchronous clear of the sticky flags
//   evt_valid  head event present
//   evt_code   key index 0..6 of the head event (0 while empty)
//   evt_level  number of queued events, 0..DEPTH
//   evt_ovf    sticky: an event was lost because the queue was full
//   evt_coll   sticky: two or more key_pulse bits were high in one cycle
// The master modport is the environment side (key detector plus consumer),
// the slave modport is the queue itself.
interface key_event_if #(
  parameter int unsigned LW = 3
) ();

  logic [6:0]    key_pulse;
  logic          evt_ready;
  logic          clr_flags;
  logic          evt_valid;
  logic [2:0]    evt_code;
  logic [LW-1:0] evt_level;
  logic          evt_ovf;
  logic          evt_coll;

  modport master (
    output key_pulse,
    output evt_ready,
    output clr_flags,
    input  evt_valid,
    input  evt_code,
    input  evt_level,
    input  evt_ovf,
    input  evt_coll
  );

  modport slave (
    input  key_pulse,
    input  evt_ready,
    input  clr_flags,
    output evt_valid,
    output evt_code,
    output evt_level,
    output evt_ovf,
    output evt_coll
  );

endinterface

// File: rtl/key_event_queue.sv
// key_event_queue
// Turns one-cycle key pulses into 3-bit key codes and queues them in a small
// FIFO for a consumer with a valid/ready handshake.
//
// Parameters
//   DEPTH  FIFO entries, power of two in 2..16
//   LW     width of evt_level, clog2(DEPTH)+1
// Ports
//   clk    system clock, all state updates on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    key_event_if slave modport (key_pulse, evt_ready, clr_flags in;
//          evt_valid, evt_code, evt_level, evt_ovf, evt_coll out)
//
// Behaviour summary
//   - Any key_pulse bit high forms one event whose code is the lowest set
//     bit; extra bits are discarded and flagged in evt_coll.
//   - The event is written on the same edge it is sampled and appears on
//     evt_valid/evt_code after that edge; there is no bypass path.
//   - A pop (evt_valid & evt_ready) and a push on the same edge keep the
//     level unchanged, including when the queue is full.
//   - A push into a full queue without a pop is dropped and sets evt_ovf.
//   - Sticky flags clear on clr_flags unless a new event sets them in the
//     same cycle.
module key_event_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  key_event_if.slave bus
);

  localparam int unsigned   PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  // Storage; contents are only observed through a valid head, so no reset.
  logic [2:0]    mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          coll_q, coll_d;

  logic          push_req;
  logic          multi_hit;
  logic [2:0]    push_code;
  logic          empty;
  logic          full;
  logic          pop_en;
  logic          push_en;
  logic          ovf_hit;

  // Lowest set bit wins; scanning downwards leaves the lowest index last.
  always_comb begin
    push_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (bus.key_pulse[i]) begin
        push_code = 3'(i);
      end
    end
  end

  assign push_req  = |bus.key_pulse;
  // x & (x-1) clears the lowest set bit; anything left means 2+ bits were set.
  assign multi_hit = (bus.key_pulse & (bus.key_pulse - 7'd1)) != 7'd0;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LevelFull);
  assign pop_en  = !empty && bus.evt_ready;
  // A pop on the same edge frees the head slot, so a full queue still accepts.
  assign push_en = push_req && (!full || pop_en);
  assign ovf_hit = push_req && full && !pop_en;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Setting takes priority over clearing.
    ovf_d  = ovf_hit   | (ovf_q  & ~bus.clr_flags);
    coll_d = multi_hit | (coll_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      coll_q   <= coll_d;
    end
  end

  // When full, wr_ptr equals rd_ptr; a push+pop then overwrites the head that
  // is leaving on this same edge, which is the intended behaviour.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // Valid is derived from the registered level so reset drops it at once.
  assign bus.evt_valid = !empty;
  assign bus.evt_code  = empty ? 3'd0 : mem_q[rd_ptr_q];
  assign bus.evt_level = level_q;
  assign bus.evt_ovf   = ovf_q;
  assign bus.evt_coll  = coll_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_key_event_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  key_event_if #(.LW(LW)) bus ();

  key_event_queue #(
    .DEPTH(DEPTH),
    .LW   (LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of key codes plus two sticky bits.
  int model_q[$];
  bit m_ovf;
  bit m_coll;
  bit m_pop, m_push, m_drop, m_multi;

  function automatic void check(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic int lowest_key(input logic [6:0] kp);
    for (int i = 0; i < 7; i++) begin
      if (kp[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      m_ovf  = 1'b0;
      m_coll = 1'b0;
    end else begin
      m_pop   = (model_q.size() > 0) && bus.evt_ready;
      m_push  = (bus.key_pulse != 7'd0);
      m_drop  = m_push && (model_q.size() == DEPTH) && !m_pop;
      m_multi = ($countones(bus.key_pulse) > 1);
      if (m_pop) void'(model_q.pop_front());
      if (m_push && !m_drop) model_q.push_back(lowest_key(bus.key_pulse));
      m_ovf  = m_drop  || (m_ovf  && !bus.clr_flags);
      m_coll = m_multi || (m_coll && !bus.clr_flags);
    end
  end

  // Outputs are compared on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("valid", 32'(bus.evt_valid), 32'(model_q.size() > 0));
    check("level", 32'(bus.evt_level), 32'(model_q.size()));
    check("code", 32'(bus.evt_code), (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
    check("ovf", 32'(bus.evt_ovf), 32'(m_ovf));
    check("coll", 32'(bus.evt_coll), 32'(m_coll));
  end

  // Drive one cycle of inputs, let the edge happen, return 1 time unit later.
  task automatic drive(input logic [6:0] kp, input logic rdy, input logic clr);
    bus.key_pulse = kp;
    bus.evt_ready = rdy;
    bus.clr_flags = clr;
    @(posedge clk);
    #1;
    bus.key_pulse = 7'd0;
    bus.evt_ready = 1'b0;
    bus.clr_flags = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         exp_seq[4];
    int         key;
    int         r;
    logic [6:0] kp;
    logic       rdy;
    logic       clr;

    exp_seq = '{1, 2, 3, 6};
    bus.key_pulse = 7'd0;
    bus.evt_ready = 1'b0;
    bus.clr_flags = 1'b0;

    #1 rst_n = 1'b0;
    #12;
    check("rst_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_level", 32'(bus.evt_level), 32'd0);
    check("rst_code", 32'(bus.evt_code), 32'd0);
    check("rst_ovf", 32'(bus.evt_ovf), 32'd0);
    check("rst_coll", 32'(bus.evt_coll), 32'd0);

    // Single key, pushed on the very first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0000100, 1'b0, 1'b0);
    check("single_valid", 32'(bus.evt_valid), 32'd1);
    check("single_code", 32'(bus.evt_code), 32'd2);
    check("single_level", 32'(bus.evt_level), 32'd1);
    drive(7'd0, 1'b1, 1'b0);
    check("single_pop_valid", 32'(bus.evt_valid), 32'd0);
    check("single_pop_level", 32'(bus.evt_level), 32'd0);

    // Pop while empty does nothing.
    drive(7'd0, 1'b1, 1'b0);
    check("empty_pop_level", 32'(bus.evt_level), 32'd0);

    // Collision.
    drive(7'b1010010, 1'b0, 1'b0);
    check("coll_code", 32'(bus.evt_code), 32'd1);
    check("coll_level", 32'(bus.evt_level), 32'd1);
    check("coll_flag", 32'(bus.evt_coll), 32'd1);
    drive(7'd0, 1'b0, 1'b1);
    check("coll_clr", 32'(bus.evt_coll), 32'd0);
    check("coll_hold_code", 32'(bus.evt_code), 32'd1);
    drive(7'd0, 1'b1, 1'b0);

    // Clear and new collision in the same cycle: set wins.
    drive(7'b0000011, 1'b0, 1'b0);
    drive(7'b0001100, 1'b0, 1'b1);
    check("coll_set_wins", 32'(bus.evt_coll), 32'd1);
    drive(7'd0, 1'b1, 1'b1);
    drive(7'd0, 1'b1, 1'b0);
    check("coll_drain_level", 32'(bus.evt_level), 32'd0);

    // Overflow: five pushes into four slots.
    for (int k = 0; k < 5; k++) drive(7'(1 << k), 1'b0, 1'b0);
    check("ovf_level", 32'(bus.evt_level), 32'd4);
    check("ovf_flag", 32'(bus.evt_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_code", 32'(bus.evt_code), 32'(i));
      drive(7'd0, 1'b1, 1'b0);
    end
    check("ovf_drain_level", 32'(bus.evt_level), 32'd0);
    drive(7'd0, 1'b0, 1'b1);
    check("ovf_clr", 32'(bus.evt_ovf), 32'd0);

    // Full queue with simultaneous push and pop.
    for (int k = 0; k < 4; k++) drive(7'(1 << k), 1'b0, 1'b0);
    drive(7'b1000000, 1'b1, 1'b0);
    check("fullpp_level", 32'(bus.evt_level), 32'd4);
    check("fullpp_ovf", 32'(bus.evt_ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fullpp_drain_code", 32'(bus.evt_code), 32'(exp_seq[i]));
      drive(7'd0, 1'b1, 1'b0);
    end
    check("fullpp_drain_valid", 32'(bus.evt_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 3; k++) drive(7'(1 << k), 1'b0, 1'b0);
    check("arst_pre_level", 32'(bus.evt_level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.evt_valid), 32'd0);
    check("arst_level", 32'(bus.evt_level), 32'd0);
    check("arst_code", 32'(bus.evt_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0100000, 1'b0, 1'b0);
    check("arst_key5_code", 32'(bus.evt_code), 32'd5);
    check("arst_key5_level", 32'(bus.evt_level), 32'd1);
    drive(7'd0, 1'b1, 1'b0);

    // Wrap: ten push/pop pairs take both pointers round several times.
    for (int i = 0; i < 10; i++) begin
      key = $urandom_range(0, 6);
      drive(7'(1 << key), 1'b0, 1'b0);
      check("wrap_code", 32'(bus.evt_code), 32'(key));
      check("wrap_level_max1", 32'(bus.evt_level <= 1), 32'd1);
      drive(7'd0, 1'b1, 1'b0);
      check("wrap_level_zero", 32'(bus.evt_level), 32'd0);
    end

    // Random traffic; ready is biased low then high to visit full and empty.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      kp = 7'd0;
      else if (r < 8) kp = 7'(1 << $urandom_range(0, 6));
      else            kp = 7'($urandom);
      if (((cyc / 250) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
      else                        rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      drive(kp, rdy, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter LW, default 3, width of evt_level, equal to clog2(DEPTH)+1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_pulse  input  7  one-cycle key pulses from the key edge detector; bit i = key i.
REQ-006 evt_ready  input  1  consumer accepts the head event this cycle.
REQ-007 clr_flags  input  1  synchronous clear of the sticky flags.
REQ-008 evt_valid  output  1  head event present.
REQ-009 evt_code  output  3  key index 0..6 of the head event.
REQ-010 evt_level  output  LW  number of queued events, 0..DEPTH.
REQ-011 evt_ovf  output  1  sticky: an event was lost because the FIFO was full.
REQ-012 evt_coll  output  1  sticky: two or more key_pulse bits were high in one cycle.

Function
REQ-013 Encode: any key_pulse bit high SHALL form one event; code = lowest set bit index.
REQ-014 Collision: more than one bit high SHALL enqueue only the lowest index, discard the rest, and set evt_coll.
REQ-015 Push: an event at edge N SHALL be written at edge N; evt_valid/evt_code SHALL reflect it after edge N (1-cycle latency, no bypass).
REQ-016 Pop: evt_valid & evt_ready at an edge SHALL advance the head and decrement evt_level.
REQ-017 evt_ready with evt_valid low SHALL have no effect.
REQ-018 evt_code SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-019 Simultaneous push and pop SHALL leave evt_level unchanged and preserve order.
REQ-020 Full (evt_level=DEPTH) with push and no pop: event SHALL be dropped, contents unchanged, evt_ovf set.
REQ-021 Full with push and pop in the same cycle: push SHALL succeed and evt_ovf SHALL stay unchanged.
REQ-022 Empty with pop: no effect; evt_level SHALL never underflow.
REQ-023 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 evt_level SHALL be a registered counter, not derived from the pointers.
REQ-025 clr_flags SHALL clear evt_ovf and evt_coll.
REQ-026 If clr_flags and a new overflow or collision occur in the same cycle, the set SHALL win.
REQ-027 FIFO order SHALL be strict first-in first-out across all 7 keys.

Reset
REQ-028 rst_n low SHALL immediately clear evt_valid, evt_level, evt_ovf, evt_coll and both pointers, without waiting for clk.
REQ-029 evt_code SHALL read 0 while empty and during reset.
REQ-030 Reset mid-operation SHALL discard all queued events.
REQ-031 The first push SHALL be accepted on the first rising edge after rst_n deasserts.
REQ-032 RAM contents need no reset.

Verification
REQ-033 Single key: key_pulse=0000100 for one cycle, evt_ready=0 -> next cycle evt_valid=1, evt_code=2, evt_level=1; evt_ready=1 for one cycle -> evt_valid=0, evt_level=0.
REQ-034 Collision: key_pulse=1010010 -> evt_code=1, evt_level=1, evt_coll=1; after clr_flags pulse -> evt_coll=0.
REQ-035 Overflow: keys 0,1,2,3,4 on consecutive cycles, evt_ready=0, DEPTH=4 -> evt_level=4, evt_ovf=1; draining yields codes 0,1,2,3.
REQ-036 Full push+pop: FIFO full with 0,1,2,3, key 6 pulse and evt_ready=1 in the same cycle -> evt_level=4, evt_ovf=0; drain yields 1,2,3,6.
REQ-037 Async reset: 3 events queued, rst_n low mid-cycle -> evt_valid=0 and evt_level=0 before the next edge; key 5 after release -> evt_code=5.
REQ-038 Wrap: 10 push/pop pairs at DEPTH=4 with random keys -> output sequence equals input sequence, evt_level never exceeds 1.
